imem_fetch_port: RTL and testbench

Parametrised, clocked instruction memory with a valid/ready fetch port and a word-wide program-load port. It sits between the PC/fetch stage and decode and replaces the combinational instruction ROM. It adds:
- configurable depth and address width,
- registered one-cycle read latency with backpressure,
- runtime program loading,
- fault reporting for misaligned and out-of-range fetches.

Storage is byte-addressed; instructions are 32-bit big-endian, with the byte at `addr` landing in bits [31:24].

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_fetch_port_if.sv | 30 +++
 rtl/imem_byte_array.sv | 31 +++
 rtl/imem_fetch_port.sv | 74 +++++++
 tb/tb_imem_fetch_port.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared constants and the address check used by both the fetch path and the
// program-load path of the instruction memory.
package imem_pkg;

    localparam int INSTR_W        = 32;
    localparam int FAULT_W        = 2;
    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;
    localparam int ADDR_MAX_W     = 128;

    // Callers zero-extend their address to ADDR_MAX_W so no high bit is ever
    // dropped before the range compare.
    function automatic logic [FAULT_W-1:0] addr_fault(
        input logic [ADDR_MAX_W-1:0] addr,
        input int unsigned           depth_bytes
    );
        logic [FAULT_W-1:0] f;
        f                 = {FAULT_W{1'b0}};
        f[FAULT_MISALIGN] = (addr[1:0] != 2'b00);
        f[FAULT_RANGE]    = (addr > ADDR_MAX_W'(depth_bytes - 32'd4));
        return f;
    endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch request/response handshake and program-load signals of the
// instruction memory, grouped so the fetch stage and memory share one bundle.
interface imem_fetch_port_if #(
    parameter int ADDR_W = 64
);
    import imem_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [INSTR_W-1:0] rsp_instr;
    logic [FAULT_W-1:0] rsp_fault;
    logic               ld_en;
    logic [ADDR_W-1:0]  ld_addr;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_err;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault, ld_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_instr, rsp_fault, ld_err
    );

endinterface

// File: rtl/imem_byte_array.sv
// Byte-organised program storage with one aligned big-endian word write port
// and one asynchronous big-endian word read port. Contents are never reset.
module imem_byte_array
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = 64,
    parameter int WIDX_W      = $clog2(DEPTH_BYTES / 4)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [WIDX_W-1:0]  i_waddr_w,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [WIDX_W-1:0]  i_raddr_w,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [7:0] r_mem [DEPTH_BYTES];

    // Word write: byte at the lowest address takes the most significant byte.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < 4; k++) begin
                r_mem[{i_waddr_w, 2'(k)}] <= i_wdata[31 - 8*k -: 8];
            end
        end
    end

    assign o_rdata = {r_mem[{i_raddr_w, 2'd0}], r_mem[{i_raddr_w, 2'd1}],
                      r_mem[{i_raddr_w, 2'd2}], r_mem[{i_raddr_w, 2'd3}]};

endmodule

// File: rtl/imem_fetch_port.sv
// Clocked instruction memory: one-cycle fetch with valid/ready backpressure,
// runtime word loading, and misalign/out-of-range fault reporting.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DEPTH_BYTES = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    imem_fetch_port_if.slave   bus
);

    localparam int WIDX_W = $clog2(DEPTH_BYTES / 4);

    logic               w_req_ready;
    logic               w_accept;
    logic [FAULT_W-1:0] w_req_fault;
    logic [FAULT_W-1:0] w_ld_fault;
    logic               w_ld_ok;
    logic [INSTR_W-1:0] w_rdata;

    logic               r_rsp_valid;
    logic [INSTR_W-1:0] r_rsp_instr;
    logic [FAULT_W-1:0] r_rsp_fault;
    logic               r_ld_err;

    // A load owns the cycle, so fetch and load never touch storage together.
    assign w_req_ready = !bus.ld_en && (!r_rsp_valid || bus.rsp_ready);
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_req_fault = addr_fault(ADDR_MAX_W'(bus.req_addr), 32'(DEPTH_BYTES));
    assign w_ld_fault  = addr_fault(ADDR_MAX_W'(bus.ld_addr), 32'(DEPTH_BYTES));
    assign w_ld_ok     = bus.ld_en && (w_ld_fault == {FAULT_W{1'b0}});

    imem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .WIDX_W      (WIDX_W)
    ) u_array (
        .i_clk     (i_clk),
        .i_we      (w_ld_ok),
        .i_waddr_w (bus.ld_addr[WIDX_W+1:2]),
        .i_wdata   (bus.ld_data),
        .i_raddr_w (bus.req_addr[WIDX_W+1:2]),
        .o_rdata   (w_rdata)
    );

    // Response register and load-reject pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= {INSTR_W{1'b0}};
            r_rsp_fault <= {FAULT_W{1'b0}};
            r_ld_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_fault <= w_req_fault;
                r_rsp_instr <= (w_req_fault == {FAULT_W{1'b0}}) ? w_rdata : {INSTR_W{1'b0}};
            end else if (bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end else begin
                r_rsp_valid <= r_rsp_valid;
            end
            r_ld_err <= bus.ld_en && !w_ld_ok;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_instr = r_rsp_instr;
    assign bus.rsp_fault = r_rsp_fault;
    assign bus.ld_err    = r_ld_err;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: directed vector table plus randomized traffic,
// both checked against a byte-array reference model of the memory.
module tb_imem_fetch_port;
    import imem_pkg::*;

    localparam int ADDR_W = 64;
    localparam int DEPTH  = 64;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    imem_fetch_port_if #(.ADDR_W(ADDR_W)) bus ();

    imem_fetch_port #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [7:0]  m_mem [DEPTH];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [1:0]  m_fault;
    logic        m_lderr;

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [63:0] ra;
        logic        rr;
        logic        le;
        logic [63:0] la;
        logic [31:0] ld;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [1:0]  e_fault;
        logic        e_lderr;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic good_addr(input logic [63:0] a);
        return (a[1:0] == 2'b00) && (a <= 64'(DEPTH - 4));
    endfunction

    // One clock cycle: drive inputs, check req_ready, advance model and DUT, check outputs.
    task automatic cycle(input logic rs, input logic rv, input logic [63:0] ra, input logic rr,
                         input logic le, input logic [63:0] la, input logic [31:0] ld,
                         output logic act_ready);
        logic exp_ready;
        logic acc;
        rst_n         = rs;
        bus.req_valid = rv;
        bus.req_addr  = ra;
        bus.rsp_ready = rr;
        bus.ld_en     = le;
        bus.ld_addr   = la;
        bus.ld_data   = ld;
        #2;
        exp_ready = !le && (!m_valid || rr);
        act_ready = bus.req_ready;
        chk("req_ready", {63'd0, act_ready}, {63'd0, exp_ready});
        acc = rv && exp_ready;
        if (!rs) begin
            m_valid = 1'b0;
            m_instr = 32'd0;
            m_fault = 2'b00;
            m_lderr = 1'b0;
        end else begin
            if (acc) begin
                m_valid = 1'b1;
                m_fault = {ra > 64'(DEPTH - 4), ra[1:0] != 2'b00};
                if (m_fault == 2'b00) begin
                    m_instr = {m_mem[ra], m_mem[ra + 1], m_mem[ra + 2], m_mem[ra + 3]};
                end else begin
                    m_instr = 32'd0;
                end
            end else if (rr) begin
                m_valid = 1'b0;
            end
            m_lderr = le && !good_addr(la);
        end
        if (le && good_addr(la)) begin
            for (int k = 0; k < 4; k++) m_mem[la + k] = ld[31 - 8*k -: 8];
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, m_valid});
        chk("rsp_instr", {32'd0, bus.rsp_instr}, {32'd0, m_instr});
        chk("rsp_fault", {62'd0, bus.rsp_fault}, {62'd0, m_fault});
        chk("ld_err",    {63'd0, bus.ld_err},    {63'd0, m_lderr});
    endtask

    function automatic vec_t mk(input logic rs, input logic rv, input logic [63:0] ra,
                                input logic rr, input logic le, input logic [63:0] la,
                                input logic [31:0] ld, input logic er, input logic ev,
                                input logic [31:0] ei, input logic [1:0] ef, input logic ee);
        vec_t v;
        v.rst_n = rs; v.rv = rv; v.ra = ra; v.rr = rr; v.le = le; v.la = la; v.ld = ld;
        v.e_ready = er; v.e_valid = ev; v.e_instr = ei; v.e_fault = ef; v.e_lderr = ee;
        return v;
    endfunction

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return {56'd0, 4'($urandom_range(0, 15)), 2'b00};
            1:       return 64'($urandom_range(0, 70));
            2:       return {$urandom, $urandom};
            default: return 64'(56 + $urandom_range(0, 8));
        endcase
    endfunction

    initial begin
        logic        rdy;
        logic [63:0] a0;
        logic [63:0] a1;
        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 64'd0;
        bus.rsp_ready = 1'b0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = 64'd0;
        bus.ld_data   = 32'd0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'd0;
        m_valid = 1'b0; m_instr = 32'd0; m_fault = 2'b00; m_lderr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("reset_instr", {32'd0, bus.rsp_instr}, 64'd0);
        chk("reset_fault", {62'd0, bus.rsp_fault}, 64'd0);
        chk("reset_lderr", {63'd0, bus.ld_err},    64'd0);

        // Preload every word with a distinct pattern
        for (int w = 0; w < DEPTH / 4; w++) begin
            cycle(1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 64'(4 * w), 32'hA5000000 + 32'(w), rdy);
        end

        //                rst  rv  req_addr                 rr  le  ld_addr  ld_data       rdy ev  instr         flt    lderr
        vecs.push_back(mk(1, 0, 64'd0,                  1, 1, 64'd0,  32'hF8400142, 0, 0, 32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 0, 64'd0,                  1, 1, 64'd4,  32'h8B020065, 0, 0, 32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd0,                  1, 0, 64'd0,  32'h0,        1, 1, 32'hF8400142, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd4,                  1, 0, 64'd0,  32'h0,        1, 1, 32'h8B020065, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'h2,                  1, 0, 64'd0,  32'h0,        1, 1, 32'h0,        2'b01, 0));
        vecs.push_back(mk(1, 1, 64'h40,                 1, 0, 64'd0,  32'h0,        1, 1, 32'h0,        2'b10, 0));
        vecs.push_back(mk(1, 1, 64'h41,                 1, 0, 64'd0,  32'h0,        1, 1, 32'h0,        2'b11, 0));
        vecs.push_back(mk(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'd0, 32'h0,        1, 1, 32'h0,        2'b10, 0));
        vecs.push_back(mk(1, 0, 64'd0,                  1, 0, 64'd0,  32'h0,        1, 0, 32'h0,        2'b10, 0));
        vecs.push_back(mk(1, 1, 64'd0,                  1, 0, 64'd0,  32'h0,        1, 1, 32'hF8400142, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd4,                  0, 0, 64'd0,  32'h0,        0, 1, 32'hF8400142, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd4,                  0, 0, 64'd0,  32'h0,        0, 1, 32'hF8400142, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd4,                  0, 0, 64'd0,  32'h0,        0, 1, 32'hF8400142, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd4,                  1, 0, 64'd0,  32'h0,        1, 1, 32'h8B020065, 2'b00, 0));
        vecs.push_back(mk(1, 0, 64'd0,                  1, 0, 64'd0,  32'h0,        1, 0, 32'h8B020065, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd8,                  1, 1, 64'd8,  32'hCB020064, 0, 0, 32'h8B020065, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd8,                  1, 0, 64'd0,  32'h0,        1, 1, 32'hCB020064, 2'b00, 0));
        vecs.push_back(mk(1, 0, 64'd0,                  1, 1, 64'd3,  32'hDEADBEEF, 0, 0, 32'hCB020064, 2'b00, 1));
        vecs.push_back(mk(1, 0, 64'd0,                  1, 1, 64'h40, 32'hDEADBEEF, 0, 0, 32'hCB020064, 2'b00, 1));
        vecs.push_back(mk(1, 0, 64'd0,                  1, 0, 64'd0,  32'h0,        1, 0, 32'hCB020064, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd0,                  1, 0, 64'd0,  32'h0,        1, 1, 32'hF8400142, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd4,                  1, 0, 64'd0,  32'h0,        1, 1, 32'h8B020065, 2'b00, 0));
        vecs.push_back(mk(1, 0, 64'd0,                  0, 0, 64'd0,  32'h0,        0, 1, 32'h8B020065, 2'b00, 0));
        vecs.push_back(mk(0, 0, 64'd0,                  0, 1, 64'd12, 32'h11223344, 0, 0, 32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd0,                  1, 0, 64'd0,  32'h0,        1, 1, 32'hF8400142, 2'b00, 0));
        vecs.push_back(mk(1, 1, 64'd12,                 1, 0, 64'd0,  32'h0,        1, 1, 32'h11223344, 2'b00, 0));

        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].rv, vecs[i].ra, vecs[i].rr, vecs[i].le,
                  vecs[i].la, vecs[i].ld, rdy);
            chk($sformatf("vec%0d_ready", i), {63'd0, rdy},              {63'd0, vecs[i].e_ready});
            chk($sformatf("vec%0d_valid", i), {63'd0, bus.rsp_valid},    {63'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d_instr", i), {32'd0, bus.rsp_instr},    {32'd0, vecs[i].e_instr});
            chk($sformatf("vec%0d_fault", i), {62'd0, bus.rsp_fault},    {62'd0, vecs[i].e_fault});
            chk($sformatf("vec%0d_lderr", i), {63'd0, bus.ld_err},       {63'd0, vecs[i].e_lderr});
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            a0 = rand_addr();
            a1 = rand_addr();
            cycle(($urandom_range(0, 49) != 0), 1'($urandom), a0, 1'($urandom),
                  ($urandom_range(0, 3) == 0), a1, $urandom, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
